// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: ALU codes, opcode/func
// fields, FSM states and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SRL = 4'b0100,
    ALU_SRA = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1000
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SUBI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_JUMP, S_ERR
  } state_e;

  typedef enum logic [1:0] {
    PC_ALU = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10, PC_RS = 2'b11
  } pc_src_e;

  typedef enum logic {
    SRCA_PC = 1'b0, SRCA_RS = 1'b1
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [3:0] {
    C_RTYPE, C_ALUI, C_LUI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILLEGAL
  } instr_cls_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decode: op/func to ALU operation, instruction
// class used by the sequencer, and the illegal-instruction flag.
module alu_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [5:0]  func_i,
  output logic [3:0]  alu_op_o,
  output instr_cls_e  cls_o,
  output logic        illegal_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    cls_o    = C_ILLEGAL;
    case (op_i)
      OP_RTYPE: begin
        case (func_i)
          FN_ADD, FN_ADDU: begin cls_o = C_RTYPE; alu_op_o = ALU_ADD; end
          FN_SUB, FN_SUBU: begin cls_o = C_RTYPE; alu_op_o = ALU_SUB; end
          FN_AND:          begin cls_o = C_RTYPE; alu_op_o = ALU_AND; end
          FN_OR:           begin cls_o = C_RTYPE; alu_op_o = ALU_OR;  end
          FN_NOR:          begin cls_o = C_RTYPE; alu_op_o = ALU_NOR; end
          FN_SLT:          begin cls_o = C_RTYPE; alu_op_o = ALU_SLT; end
          FN_SLL:          begin cls_o = C_RTYPE; alu_op_o = ALU_SLL; end
          FN_SRL:          begin cls_o = C_RTYPE; alu_op_o = ALU_SRL; end
          FN_SRA:          begin cls_o = C_RTYPE; alu_op_o = ALU_SRA; end
          FN_JR:           cls_o = C_JR;
          default: ;
        endcase
      end
      OP_ADDI: begin cls_o = C_ALUI; alu_op_o = ALU_ADD; end
      OP_SUBI: begin cls_o = C_ALUI; alu_op_o = ALU_SUB; end
      OP_ANDI: begin cls_o = C_ALUI; alu_op_o = ALU_AND; end
      OP_ORI:  begin cls_o = C_ALUI; alu_op_o = ALU_OR;  end
      OP_SLTI: begin cls_o = C_ALUI; alu_op_o = ALU_SLT; end
      OP_LUI:  begin cls_o = C_LUI;  alu_op_o = ALU_ADD; end
      OP_LW:   begin cls_o = C_LW;   alu_op_o = ALU_ADD; end
      OP_SW:   begin cls_o = C_SW;   alu_op_o = ALU_ADD; end
      OP_BEQ:  cls_o = C_BEQ;
      OP_BNE:  cls_o = C_BNE;
      OP_J:    cls_o = C_J;
      OP_JAL:  cls_o = C_JAL;
      default: ;
    endcase
    illegal_o = (cls_o == C_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and watches memory handshakes for timeout.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       link,
  output logic       illegal,
  output logic       mem_err
);

  localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            run_q;

  logic [3:0]      dec_alu_op;
  instr_cls_e      cls;
  logic            dec_illegal;

  alu_decode u_alu_decode (
    .op_i      (op),
    .func_i    (func),
    .alu_op_o  (dec_alu_op),
    .cls_o     (cls),
    .illegal_o (dec_illegal)
  );

  // The counter only survives across stalled FETCH/MEM cycles, so any state
  // change (including entry to FETCH or MEM) leaves it cleared.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    mem_err_d = mem_err_q;
    case (state_q)
      S_FETCH, S_MEM: begin
        if (run_q) begin
          if (mem_ready) begin
            if (state_q == S_FETCH)  state_d = S_DECODE;
            else if (cls == C_SW)    state_d = S_FETCH;
            else                     state_d = S_WB;
          end else if (cnt_q == LAST_WAIT) begin
            state_d   = S_ERR;
            mem_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DECODE: begin
        case (cls)
          C_BEQ, C_BNE:     state_d = S_BRANCH;
          C_J, C_JAL, C_JR: state_d = S_JUMP;
          C_ILLEGAL:        state_d = S_FETCH;
          default:          state_d = S_EXEC;
        endcase
      end
      S_EXEC:   state_d = (cls == C_LW || cls == C_SW) ? S_MEM : S_WB;
      S_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end

  // run_q holds every output low from reset until the first clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
      run_q     <= 1'b1;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    alu_op     = ALU_AND;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RT;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    link       = 1'b0;
    illegal    = 1'b0;
    mem_err    = mem_err_q;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          alu_op    = ALU_ADD;
          illegal   = dec_illegal;
        end
        S_EXEC: begin
          alu_src_a = SRCA_RS;
          alu_src_b = (cls == C_RTYPE) ? SRCB_RT : SRCB_IMM;
          alu_op    = dec_alu_op;
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (cls == C_SW);
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (cls == C_RTYPE);
          mem_to_reg = (cls == C_LW || cls == C_LUI);
        end
        S_BRANCH: begin
          alu_src_a = SRCA_RS;
          alu_op    = ALU_SUB;
          pc_src    = PC_BRANCH;
          pc_write  = (cls == C_BEQ) ? zero : !zero;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_src    = (cls == C_JR) ? PC_RS : PC_JUMP;
          reg_write = (cls == C_JAL);
          link      = (cls == C_JAL);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle output traces compared
// against a phase-level reference model, with a reactive memory responder.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_op;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, link, illegal, mem_err;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write, reg_dst, mem_to_reg, link, illegal, mem_err;
  } obs_t;

  typedef enum {K_R, K_I, K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_BAD} kind_t;

  multicycle_ctrl #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .link(link), .illegal(illegal),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t s;
    s = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_op, alu_src_a,
         alu_src_b, reg_write, reg_dst, mem_to_reg, link, illegal, mem_err};
    return s;
  endfunction

  function automatic kind_t kind_of(input logic [5:0] o, input logic [5:0] f);
    if (o == OP_RTYPE) begin
      if (f == FN_JR) return K_JR;
      if (f inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_NOR,
                    FN_SLT, FN_SLL, FN_SRL, FN_SRA}) return K_R;
      return K_BAD;
    end
    if (o inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI}) return K_I;
    if (o == OP_LUI) return K_LUI;
    if (o == OP_LW)  return K_LW;
    if (o == OP_SW)  return K_SW;
    if (o == OP_BEQ) return K_BEQ;
    if (o == OP_BNE) return K_BNE;
    if (o == OP_J)   return K_J;
    if (o == OP_JAL) return K_JAL;
    return K_BAD;
  endfunction

  function automatic logic [3:0] alu_code(input logic [5:0] o, input logic [5:0] f);
    if (o == OP_RTYPE) begin
      if (f == FN_SUB || f == FN_SUBU) return 4'b0110;
      if (f == FN_AND) return 4'b0000;
      if (f == FN_OR)  return 4'b0001;
      if (f == FN_NOR) return 4'b1000;
      if (f == FN_SLT) return 4'b0111;
      if (f == FN_SLL) return 4'b0011;
      if (f == FN_SRL) return 4'b0100;
      if (f == FN_SRA) return 4'b0101;
      return 4'b0010;
    end
    if (o == OP_SUBI) return 4'b0110;
    if (o == OP_ANDI) return 4'b0000;
    if (o == OP_ORI)  return 4'b0001;
    if (o == OP_SLTI) return 4'b0111;
    return 4'b0010;
  endfunction

  // Expected trace for one instruction: fd/md are wait cycles before mem_ready.
  function automatic void model(input logic [5:0] o, input logic [5:0] f, input logic z,
                                input int fd, input int md, output obs_t e[$]);
    kind_t k = kind_of(o, f);
    obs_t  v;
    e = {};
    for (int i = 0; i <= fd; i++) begin
      v = '0; v.mem_req = 1; v.alu_src_b = 2'b01; v.alu_op = 4'b0010;
      if (i == fd) begin v.ir_write = 1; v.pc_write = 1; end
      e.push_back(v);
    end
    v = '0; v.alu_src_b = 2'b11; v.alu_op = 4'b0010; v.illegal = (k == K_BAD);
    e.push_back(v);
    if (k == K_BAD) return;
    if (k == K_BEQ || k == K_BNE) begin
      v = '0; v.alu_src_a = 1; v.alu_op = 4'b0110; v.pc_src = 2'b01;
      v.pc_write = (k == K_BEQ) ? z : !z;
      e.push_back(v);
      return;
    end
    if (k == K_J || k == K_JAL || k == K_JR) begin
      v = '0; v.pc_write = 1; v.pc_src = (k == K_JR) ? 2'b11 : 2'b10;
      v.reg_write = (k == K_JAL); v.link = (k == K_JAL);
      e.push_back(v);
      return;
    end
    v = '0; v.alu_src_a = 1; v.alu_src_b = (k == K_R) ? 2'b00 : 2'b10; v.alu_op = alu_code(o, f);
    e.push_back(v);
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= md; i++) begin
        v = '0; v.mem_req = 1; v.iord = 1; v.mem_we = (k == K_SW);
        e.push_back(v);
      end
      if (k == K_SW) return;
    end
    v = '0; v.reg_write = 1; v.reg_dst = (k == K_R); v.mem_to_reg = (k == K_LW || k == K_LUI);
    e.push_back(v);
  endfunction

  // Drives one instruction for n cycles; memory answers a request after fd
  // (fetch) or md (data) stalled cycles and toggles mem_ready randomly otherwise.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fd, input int md, input int n, output obs_t g[$]);
    int wc = 0;
    g = {};
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) begin op = o; func = f; zero = z; end
      if (mem_req) mem_ready = (wc >= (iord ? md : fd));
      else         mem_ready = 1'($urandom_range(0, 1));
      #1 g.push_back(sample());
      if (mem_req) wc = mem_ready ? 0 : wc + 1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t g, e;
    rst_n = 1'b0; op = OP_RTYPE; func = FN_ADD; mem_ready = 1'b1;
    #1;
    checks++;
    if (sample() !== '0) begin fails++; $display("FAIL reset_async: got %h expected 0", sample()); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sample() !== '0) begin fails++; $display("FAIL reset_held: got %h expected 0", sample()); end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    #1 g = sample();
    e = '0; e.mem_req = 1; e.alu_src_b = 2'b01; e.alu_op = 4'b0010;
    checks++;
    if (g !== e) begin fails++; $display("FAIL reset_first_fetch: got %h expected %h", g, e); end
    apply_reset();
  endtask

  task automatic test_add();
    obs_t e[$], g[$];
    model(OP_RTYPE, FN_ADD, 1'b0, 0, 0, e);
    run_instr(OP_RTYPE, FN_ADD, 1'b0, 0, 0, e.size(), g);
    foreach (e[i]) begin
      checks++;
      if (g[i] !== e[i]) begin fails++; $display("FAIL add c%0d: got %h expected %h", i, g[i], e[i]); end
    end
  endtask

  task automatic test_lw_delay();
    obs_t e[$], g[$];
    model(OP_LW, 6'h15, 1'b0, 0, 3, e);
    run_instr(OP_LW, 6'h15, 1'b0, 0, 3, e.size(), g);
    foreach (e[i]) begin
      checks++;
      if (g[i] !== e[i]) begin fails++; $display("FAIL lw_delay c%0d: got %h expected %h", i, g[i], e[i]); end
    end
  endtask

  task automatic test_branch();
    obs_t e[$], g[$];
    for (int t = 0; t < 4; t++) begin
      logic [5:0] o = (t < 2) ? OP_BEQ : OP_BNE;
      logic       z = t[0];
      model(o, 6'h2a, z, 1, 0, e);
      run_instr(o, 6'h2a, z, 1, 0, e.size(), g);
      foreach (e[i]) begin
        checks++;
        if (g[i] !== e[i]) begin fails++; $display("FAIL branch%0d c%0d: got %h expected %h", t, i, g[i], e[i]); end
      end
    end
  endtask

  task automatic test_jump();
    obs_t e[$], g[$];
    logic [5:0] ops[3] = '{OP_J, OP_JAL, OP_RTYPE};
    for (int t = 0; t < 3; t++) begin
      model(ops[t], FN_JR, 1'b0, 0, 0, e);
      run_instr(ops[t], FN_JR, 1'b0, 0, 0, e.size(), g);
      foreach (e[i]) begin
        checks++;
        if (g[i] !== e[i]) begin fails++; $display("FAIL jump%0d c%0d: got %h expected %h", t, i, g[i], e[i]); end
      end
    end
  endtask

  task automatic test_illegal();
    obs_t e[$], g[$];
    logic [5:0] ops[2] = '{6'b111111, OP_RTYPE};
    for (int t = 0; t < 2; t++) begin
      model(ops[t], 6'b111111, 1'b0, 0, 0, e);
      run_instr(ops[t], 6'b111111, 1'b0, 0, 0, e.size(), g);
      foreach (e[i]) begin
        checks++;
        if (g[i] !== e[i]) begin fails++; $display("FAIL illegal%0d c%0d: got %h expected %h", t, i, g[i], e[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e[$], g[$];
    logic [5:0] tops[22] = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE,
                             OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_ADDI, OP_SUBI,
                             OP_ANDI, OP_ORI, OP_SLTI, OP_LUI, OP_LW, OP_SW, OP_BEQ,
                             OP_BNE, OP_JAL, 6'b010101};
    logic [5:0] tfns[10] = '{FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_NOR,
                             FN_SLT, FN_SLL, FN_SRL, FN_SRA};
    for (int t = 0; t < 40; t++) begin
      int         idx = $urandom_range(0, 21);
      logic [5:0] o   = tops[idx];
      logic [5:0] f   = (idx < 10) ? tfns[idx] : 6'($urandom_range(0, 63));
      logic       z   = 1'($urandom_range(0, 1));
      int         fd  = $urandom_range(0, 3);
      int         md  = $urandom_range(0, 3);
      model(o, f, z, fd, md, e);
      run_instr(o, f, z, fd, md, e.size(), g);
      foreach (e[i]) begin
        checks++;
        if (g[i] !== e[i]) begin
          fails++;
          $display("FAIL rand%0d op=%b fn=%b c%0d: got %h expected %h", t, o, f, i, g[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_timeout_edge();
    obs_t e[$], g[$];
    model(OP_RTYPE, FN_OR, 1'b0, 14, 0, e);
    run_instr(OP_RTYPE, FN_OR, 1'b0, 14, 0, e.size(), g);
    foreach (e[i]) begin
      checks++;
      if (g[i] !== e[i]) begin fails++; $display("FAIL timeout_edge c%0d: got %h expected %h", i, g[i], e[i]); end
    end
  endtask

  task automatic test_timeout();
    obs_t e[$], g[$];
    obs_t v;
    e = {};
    for (int i = 0; i < 20; i++) begin
      v = '0;
      if (i < 15) begin v.mem_req = 1; v.alu_src_b = 2'b01; v.alu_op = 4'b0010; end
      else v.mem_err = 1;
      e.push_back(v);
    end
    run_instr(OP_RTYPE, FN_ADD, 1'b0, 1000, 0, e.size(), g);
    foreach (e[i]) begin
      checks++;
      if (g[i] !== e[i]) begin fails++; $display("FAIL timeout c%0d: got %h expected %h", i, g[i], e[i]); end
    end
  endtask

  task automatic test_reset_mid_sw();
    obs_t e[$], g[$];
    apply_reset();
    model(OP_SW, 6'h00, 1'b0, 0, 10, e);
    run_instr(OP_SW, 6'h00, 1'b0, 0, 10, 5, g);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (g[i] !== e[i]) begin fails++; $display("FAIL sw_pre_reset c%0d: got %h expected %h", i, g[i], e[i]); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sample() !== '0) begin fails++; $display("FAIL sw_reset_outputs: got %h expected 0", sample()); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model(OP_RTYPE, FN_ADD, 1'b0, 0, 0, e);
    run_instr(OP_RTYPE, FN_ADD, 1'b0, 0, 0, e.size(), g);
    foreach (e[i]) begin
      checks++;
      if (g[i] !== e[i]) begin fails++; $display("FAIL sw_post_reset c%0d: got %h expected %h", i, g[i], e[i]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_lw_delay();
    test_branch();
    test_jump();
    test_illegal();
    test_back_to_back();
    test_timeout_edge();
    test_timeout();
    test_reset_mid_sw();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning the number of cycles allowed waiting on mem_ready before an error is declared.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 op  in  6  opcode field of the instruction register.
REQ-006 func  in  6  function field of the instruction register.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory completion for the current request.
REQ-009 mem_req, mem_we, iord  out  1 each  memory request, write enable, and address select (0=PC, 1=ALUOut).
REQ-010 ir_write, pc_write  out  1 each  load the instruction register; load the PC.
REQ-011 pc_src  out  2  PC source: 00=ALU (PC+4), 01=branch target, 10=jump target, 11=register rs.
REQ-012 alu_op  out  4  ALU operation code; alu_src_a out 1 (0=PC, 1=rs); alu_src_b out 2 (00=rt, 01=4, 10=imm, 11=imm<<2).
REQ-013 reg_write, reg_dst, mem_to_reg, link  out  1 each  register-file write, rd select, memory data select, and $ra write for jal.
REQ-014 illegal  out  1  one-cycle pulse on an undecodable instruction; mem_err out 1, sticky memory-timeout flag.

Function
REQ-015 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP and ERR, with Moore outputs that are 0 unless listed below.
REQ-016 FETCH SHALL assert mem_req with iord=0, alu_src_a=0, alu_src_b=01 and alu_op=ADD, and hold these until mem_ready.
REQ-017 On mem_ready in FETCH, the block SHALL pulse ir_write and pc_write (pc_src=00) and move to DECODE.
REQ-018 DECODE SHALL drive alu_src_b=11 with alu_op=ADD to form the branch target.
REQ-019 From DECODE, R-type, andi, ori, slti, addi, subi, lw, sw and lui SHALL go to EXEC; beq and bne SHALL go to BRANCH; j, jal and jr SHALL go to JUMP.
REQ-020 Any other op/func SHALL pulse illegal and return to FETCH.
REQ-021 EXEC SHALL drive alu_src_a=1, alu_src_b=00 for R-type or 10 otherwise, and the decoded alu_op; lw and sw then go to MEM, all others to WB.
REQ-022 ALU decoding SHALL map add/addu/addi/lw/sw/lui to ADD, sub/subu/subi to SUB, and/andi to AND, or/ori to OR, nor to NOR, slt/slti to SLT, and sll/srl/sra to SLL/SRL/SRA.
REQ-023 MEM SHALL assert mem_req with iord=1 and mem_we=1 for sw, waiting for mem_ready; on mem_ready, sw goes to FETCH and lw goes to WB.
REQ-024 WB SHALL pulse reg_write, with reg_dst=1 for R-type and mem_to_reg=1 for lw and lui, then go to FETCH.
REQ-025 BRANCH SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=SUB.
REQ-026 In BRANCH, pc_write SHALL be (beq AND zero) OR (bne AND NOT zero) with pc_src=01, then the FSM goes to FETCH.
REQ-027 JUMP SHALL pulse pc_write with pc_src=10 for j/jal or 11 for jr; jal SHALL also pulse reg_write and link; the FSM then goes to FETCH.
REQ-028 A wait counter SHALL clear on each entry to FETCH or MEM and increment on each cycle of mem_req without mem_ready.
REQ-029 When the counter reaches MAX_WAIT, the FSM SHALL enter ERR, drop mem_req and set mem_err; ERR is terminal until reset.
REQ-030 mem_ready arriving in the same cycle that the counter reaches MAX_WAIT SHALL be accepted as completion, with no error.
REQ-031 mem_ready outside FETCH or MEM SHALL be ignored.
REQ-032 With zero-wait memory, instruction latency SHALL be: R-type/I-type ALU 4 cycles, lw 5, sw 4, branch 3, jump 3.

Reset
REQ-033 rst_n low SHALL asynchronously force state=FETCH, counter=0 and mem_err=0, and SHALL force all outputs to 0, including mem_req.
REQ-034 The first mem_req SHALL appear in the first clk cycle after rst_n deasserts.
REQ-035 Reset asserted mid-operation SHALL abandon any outstanding memory request with no write pulse issued.

Structure
REQ-036 A shared package ctrl_pkg SHALL hold the ALU codes (AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SRA 0101, SUB 0110, SLT 0111, NOR 1000), the opcode/func constants, the state encoding and the pc_src/alu_src encodings.
REQ-037 The combinational op/func to alu_op/illegal mapping SHALL be a sub-module named alu_decode.

Verification
REQ-038 add (op=0, func=100000) with zero-wait memory -> states FETCH, DECODE, EXEC, WB; alu_op=0010 in EXEC; reg_write=1 and reg_dst=1 in cycle 4.
REQ-039 lw (op=100011) with mem_ready delayed 3 cycles in MEM -> mem_req and iord=1 held for 4 cycles; WB shows mem_to_reg=1; total 8 cycles.
REQ-040 beq (op=000100) with zero=1 -> pc_write=1 and pc_src=01 in BRANCH; with zero=0 -> pc_write=0; both return to FETCH.
REQ-041 jal (op=000011) -> JUMP with pc_src=10 and pc_write=link=reg_write=1; jr (func=001000) -> pc_src=11 and reg_write=0.
REQ-042 mem_ready held low for 15 cycles in FETCH -> ERR, mem_req=0, mem_err=1; mem_ready on cycle 15 -> DECODE with no error.
REQ-043 rst_n pulsed low during MEM of sw -> outputs are 0 at once; after release, FETCH with mem_req=1 and no mem_we pulse.
